// File: rtl/riscv_instr_arb_pkg.sv
// Purpose: shared constants and the round-robin pick function for the instruction-port arbiter.
// Latency: n/a (types, constants and a pure combinational function).
// Backpressure: n/a.
package riscv_instr_arb_pkg;

    // Default parameter values for the arbiter top.
    localparam int NB_REQ_DEF          = 4;
    localparam int ADDR_WIDTH_DEF      = 32;
    localparam int DATA_WIDTH_DEF      = 128;
    localparam int MAX_OUTSTANDING_DEF = 2;

    // Width of every performance counter.
    localparam int CNT_W = 16;

    // Requester vectors are handled at the largest legal width inside the
    // pick function so it needs no parameterisation; callers zero-extend.
    localparam int MAX_REQ = 8;
    localparam int IDX_W   = 3;

    // One-hot winner: first set bit of req searched upward from ptr, wrapping at n.
    function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                                   input logic [IDX_W-1:0]   ptr,
                                                   input int                 n);
        logic [MAX_REQ-1:0] pick;
        logic               found;
        logic [IDX_W-1:0]   idx;
        pick  = '0;
        found = 1'b0;
        for (int i = 0; i < MAX_REQ; i++) begin
            idx = IDX_W'((int'(ptr) + i) % n);
            if (i < n && !found && req[idx]) begin
                pick[idx] = 1'b1;
                found     = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/riscv_instr_arb_id_fifo.sv
// Purpose: in-order queue of one-hot requester IDs for granted, unanswered fetches.
// Latency: push visible at head the cycle after; head is a registered read, pop takes effect at the edge.
// Backpressure: full/empty exported; pushes while full and pops while empty are ignored.
module riscv_instr_arb_id_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_cnt;
    logic             w_do_push;
    logic             w_do_pop;

    assign full      = (r_cnt == CW'(DEPTH));
    assign empty     = (r_cnt == '0);
    assign head      = r_mem[r_rd_ptr];
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    // Storage write; contents need no reset because the count qualifies them.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_dat;
        end
    end

    // Pointer and occupancy update; simultaneous push and pop leave the count unchanged.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= (r_wr_ptr == PW'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= (r_rd_ptr == PW'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule

// File: rtl/riscv_instr_port_arbiter.sv
// Purpose: round-robin share of one instruction-memory port among NB_REQ prefetchers; optional perf counters via INSTR_ARB_PERF_EN.
// Latency: request and response paths are combinational (zero cycles); grant order tracked in an ID queue.
// Backpressure: waits on mem_gnt_i with the winner locked; mem_req_o drops while MAX_OUTSTANDING fetches are in flight.
module riscv_instr_port_arbiter
    import riscv_instr_arb_pkg::*;
#(
    parameter int NB_REQ          = NB_REQ_DEF,
    parameter int ADDR_WIDTH      = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH      = DATA_WIDTH_DEF,
    parameter int MAX_OUTSTANDING = MAX_OUTSTANDING_DEF
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NB_REQ-1:0]            req_i,
    input  logic [NB_REQ*ADDR_WIDTH-1:0] addr_i,
    output logic [NB_REQ-1:0]            gnt_o,
    output logic [NB_REQ-1:0]            rvalid_o,
    output logic [DATA_WIDTH-1:0]        rdata_o,
    output logic                         mem_req_o,
    output logic [ADDR_WIDTH-1:0]        mem_addr_o,
    input  logic                         mem_gnt_i,
    input  logic                         mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0]        mem_rdata_i,
    output logic                         busy_o,
    output logic                         err_o
`ifdef INSTR_ARB_PERF_EN
    ,
    output logic [NB_REQ*CNT_W-1:0]      grant_cnt_o,
    output logic [CNT_W-1:0]             stall_cnt_o
`endif
);

    logic [IDX_W-1:0]      r_rr_ptr;
    logic                  r_lock_vld;
    logic [IDX_W-1:0]      r_lock_idx;
    logic                  r_err;

    logic [MAX_REQ-1:0]    w_req_ext;
    logic [MAX_REQ-1:0]    w_pick;
    logic [IDX_W-1:0]      w_pick_idx;
    logic                  w_lock_hit;
    logic [IDX_W-1:0]      w_win_idx;
    logic [NB_REQ-1:0]     w_win_oh;
    logic                  w_any_req;
    logic                  w_mem_req;
    logic                  w_hs;
    logic                  w_pop;
    logic                  w_fifo_full;
    logic                  w_fifo_empty;
    logic [NB_REQ-1:0]     w_fifo_head;
    logic [ADDR_WIDTH-1:0] w_addr;

    assign w_req_ext = MAX_REQ'(req_i);
    assign w_pick    = rr_pick(w_req_ext, r_rr_ptr, NB_REQ);
    assign w_any_req = |req_i;

    // Convert the round-robin one-hot pick into an index.
    always_comb begin
        w_pick_idx = '0;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (w_pick[i]) begin
                w_pick_idx = IDX_W'(i);
            end
        end
    end

    // A locked requester keeps the port only while it still requests.
    assign w_lock_hit = r_lock_vld && w_req_ext[r_lock_idx];
    assign w_win_idx  = w_lock_hit ? r_lock_idx : w_pick_idx;
    assign w_win_oh   = NB_REQ'(1) << w_win_idx;

    // Full comes from registered occupancy only, so no mem_rvalid_i -> mem_req_o path.
    assign w_mem_req = rst_n && w_any_req && !w_fifo_full;
    assign w_hs      = w_mem_req && mem_gnt_i;
    assign w_pop     = rst_n && mem_rvalid_i && !w_fifo_empty;

    // Address follows the current winner live, so a redirect while waiting is seen.
    always_comb begin
        w_addr = '0;
        for (int k = 0; k < NB_REQ; k++) begin
            if (w_win_idx == IDX_W'(k)) begin
                w_addr = addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
            end
        end
    end

    assign mem_req_o  = w_mem_req;
    assign mem_addr_o = w_any_req ? w_addr : '0;
    assign gnt_o      = w_hs ? w_win_oh : '0;
    assign rvalid_o   = w_pop ? w_fifo_head : '0;
    assign rdata_o    = mem_rdata_i;
    assign busy_o     = !w_fifo_empty;
    assign err_o      = r_err;

    // Round-robin pointer moves past the winner on every handshake.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rr_ptr <= '0;
        end else if (w_hs) begin
            r_rr_ptr <= (w_win_idx == IDX_W'(NB_REQ - 1)) ? '0 : w_win_idx + 1'b1;
        end
    end

    // Lock holds the waiting winner until handshake or until it drops its request.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_lock_vld <= 1'b0;
            r_lock_idx <= '0;
        end else if (w_hs) begin
            r_lock_vld <= 1'b0;
        end else if (w_mem_req) begin
            r_lock_vld <= 1'b1;
            r_lock_idx <= w_win_idx;
        end else if (!w_lock_hit) begin
            r_lock_vld <= 1'b0;
        end
    end

    // Sticky error on a response that has no outstanding fetch to match.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (mem_rvalid_i && w_fifo_empty) begin
            r_err <= 1'b1;
        end
    end

    riscv_instr_arb_id_fifo #(
        .WIDTH (NB_REQ),
        .DEPTH (MAX_OUTSTANDING)
    ) u_id_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (w_hs),
        .push_dat (w_win_oh),
        .pop      (w_pop),
        .full     (w_fifo_full),
        .empty    (w_fifo_empty),
        .head     (w_fifo_head)
    );

`ifdef INSTR_ARB_PERF_EN
    logic [CNT_W-1:0] r_grant_cnt [NB_REQ];
    logic [CNT_W-1:0] r_stall_cnt;

    // Saturating per-requester grant counters and a stall-cycle counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < NB_REQ; k++) begin
                r_grant_cnt[k] <= '0;
            end
            r_stall_cnt <= '0;
        end else begin
            for (int k = 0; k < NB_REQ; k++) begin
                if (w_hs && w_win_idx == IDX_W'(k) && r_grant_cnt[k] != '1) begin
                    r_grant_cnt[k] <= r_grant_cnt[k] + 1'b1;
                end
            end
            if (w_any_req && !w_hs && r_stall_cnt != '1) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
        end
    end

    // Flatten the grant counters onto the output bus.
    always_comb begin
        grant_cnt_o = '0;
        for (int k = 0; k < NB_REQ; k++) begin
            grant_cnt_o[k*CNT_W +: CNT_W] = r_grant_cnt[k];
        end
    end

    assign stall_cnt_o = r_stall_cnt;
`endif

endmodule

// File: tb/tb_riscv_instr_port_arbiter.sv
// Purpose: self-checking bench for riscv_instr_port_arbiter with a response-order scoreboard.
// Latency: inputs driven 1 time unit after the rising edge, outputs sampled on the falling edge.
// Backpressure: memory grant/response are driven directly by each scenario task.
module tb_riscv_instr_port_arbiter;

    localparam int NB  = 4;
    localparam int AW  = 32;
    localparam int DW  = 128;
    localparam logic [3:0] RR_EXP [4] = '{4'b0001, 4'b0100, 4'b0001, 4'b0100};

    logic            clk = 1'b0;
    logic            rst_n;
    logic [NB-1:0]   req_i;
    logic [NB*AW-1:0] addr_i;
    logic [NB-1:0]   gnt_o;
    logic [NB-1:0]   rvalid_o;
    logic [DW-1:0]   rdata_o;
    logic            mem_req_o;
    logic [AW-1:0]   mem_addr_o;
    logic            mem_gnt_i;
    logic            mem_rvalid_i;
    logic [DW-1:0]   mem_rdata_i;
    logic            busy_o;
    logic            err_o;
`ifdef INSTR_ARB_PERF_EN
    logic [NB*16-1:0] grant_cnt_o;
    logic [15:0]      stall_cnt_o;
`endif

    int total = 0;
    int bad   = 0;
    logic [NB-1:0] sb [$];
    logic [NB-1:0] exp_id;

    always #5 clk = ~clk;

    riscv_instr_port_arbiter #(
        .NB_REQ (NB), .ADDR_WIDTH (AW), .DATA_WIDTH (DW), .MAX_OUTSTANDING (2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_i        (req_i),
        .addr_i       (addr_i),
        .gnt_o        (gnt_o),
        .rvalid_o     (rvalid_o),
        .rdata_o      (rdata_o),
        .mem_req_o    (mem_req_o),
        .mem_addr_o   (mem_addr_o),
        .mem_gnt_i    (mem_gnt_i),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_rdata_i  (mem_rdata_i),
        .busy_o       (busy_o),
        .err_o        (err_o)
`ifdef INSTR_ARB_PERF_EN
        ,
        .grant_cnt_o  (grant_cnt_o),
        .stall_cnt_o  (stall_cnt_o)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req_i        = '0;
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b0;
    endtask

    // Pop the scoreboard and compare the routed response against it.
    task automatic sb_check_rvalid(input string name);
        total++;
        if (sb.size() == 0) begin
            bad++;
            $display("FAIL %s: rvalid_o=%b but no expected response queued", name, rvalid_o);
        end else begin
            exp_id = sb.pop_front();
            if (rvalid_o !== exp_id) begin
                bad++;
                $display("FAIL %s: rvalid_o got %b want %b", name, rvalid_o, exp_id);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_i = '1; mem_gnt_i = 1'b1; mem_rvalid_i = 1'b1;
        addr_i = '0; mem_rdata_i = '0;
        @(negedge clk);
        total++; if (mem_req_o !== 1'b0) begin bad++; $display("FAIL reset_mem_req: got %b want 0", mem_req_o); end
        total++; if (gnt_o !== 4'b0000) begin bad++; $display("FAIL reset_gnt: got %b want 0000", gnt_o); end
        total++; if (rvalid_o !== 4'b0000) begin bad++; $display("FAIL reset_rvalid: got %b want 0000", rvalid_o); end
        step(); step();
        rst_n = 1'b1;
        idle_inputs();
        @(negedge clk);
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy_o); end
        total++; if (err_o !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", err_o); end
        total++; if (mem_req_o !== 1'b0) begin bad++; $display("FAIL reset_idle_req: got %b want 0", mem_req_o); end
        step();
    endtask

    task automatic test_round_robin();
        logic [DW-1:0] dat;
        for (int i = 0; i < 5; i++) begin
            req_i        = (i < 4) ? 4'b0101 : 4'b0000;
            mem_gnt_i    = (i < 4);
            mem_rvalid_i = (i >= 1);
            dat          = {4{32'hCAFE0000 | 32'(i)}};
            mem_rdata_i  = dat;
            @(negedge clk);
            if (i >= 1) begin
                sb_check_rvalid($sformatf("rr_rvalid[%0d]", i));
                total++;
                if (rdata_o !== dat) begin bad++; $display("FAIL rr_rdata[%0d]: got %h want %h", i, rdata_o, dat); end
            end
            if (i < 4) begin
                total++;
                if (gnt_o !== RR_EXP[i]) begin bad++; $display("FAIL rr_gnt[%0d]: got %b want %b", i, gnt_o, RR_EXP[i]); end
                sb.push_back(RR_EXP[i]);
            end
            step();
        end
        idle_inputs();
        @(negedge clk);
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL rr_busy_end: got %b want 0", busy_o); end
        step();
    endtask

    task automatic test_lock();
        // Round-robin pointer is at 3 here, so an unlocked pick would favour requester 0.
        addr_i[0*AW +: AW] = 32'h1000_0000;
        addr_i[1*AW +: AW] = 32'h1111_0000;
        req_i = 4'b0010; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
        @(negedge clk);
        total++; if (mem_req_o !== 1'b1) begin bad++; $display("FAIL lock_req_c0: got %b want 1", mem_req_o); end
        total++; if (mem_addr_o !== 32'h1111_0000) begin bad++; $display("FAIL lock_addr_c0: got %h want 11110000", mem_addr_o); end
        total++; if (gnt_o !== 4'b0000) begin bad++; $display("FAIL lock_gnt_c0: got %b want 0000", gnt_o); end
        step();
        req_i = 4'b0011;
        @(negedge clk);
        total++; if (mem_addr_o !== 32'h1111_0000) begin bad++; $display("FAIL lock_addr_c1: got %h want 11110000", mem_addr_o); end
        step();
        addr_i[1*AW +: AW] = 32'h1111_2222;
        @(negedge clk);
        total++; if (mem_addr_o !== 32'h1111_2222) begin bad++; $display("FAIL lock_addr_redirect: got %h want 11112222", mem_addr_o); end
        step();
        mem_gnt_i = 1'b1;
        @(negedge clk);
        total++; if (gnt_o !== 4'b0010) begin bad++; $display("FAIL lock_gnt: got %b want 0010", gnt_o); end
        sb.push_back(4'b0010);
        step();
        req_i = '0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1;
        @(negedge clk);
        sb_check_rvalid("lock_rvalid");
        step();
        idle_inputs();
        step();
    endtask

    task automatic test_full();
        // Pointer is at 2 after the lock scenario granted requester 1.
        req_i = 4'b1000; mem_gnt_i = 1'b1; mem_rvalid_i = 1'b0;
        @(negedge clk);
        total++; if (gnt_o !== 4'b1000) begin bad++; $display("FAIL full_gnt0: got %b want 1000", gnt_o); end
        sb.push_back(4'b1000);
        step();
        req_i = 4'b1001;
        @(negedge clk);
        total++; if (gnt_o !== 4'b0001) begin bad++; $display("FAIL full_gnt1: got %b want 0001", gnt_o); end
        sb.push_back(4'b0001);
        step();
        mem_rvalid_i = 1'b1;
        @(negedge clk);
        total++; if (mem_req_o !== 1'b0) begin bad++; $display("FAIL full_req_low: got %b want 0", mem_req_o); end
        total++; if (gnt_o !== 4'b0000) begin bad++; $display("FAIL full_gnt_blocked: got %b want 0000", gnt_o); end
        total++; if (busy_o !== 1'b1) begin bad++; $display("FAIL full_busy: got %b want 1", busy_o); end
        sb_check_rvalid("full_first_rsp");
        step();
        mem_rvalid_i = 1'b0;
        @(negedge clk);
        total++; if (mem_req_o !== 1'b1) begin bad++; $display("FAIL full_req_back: got %b want 1", mem_req_o); end
        total++; if (gnt_o !== 4'b1000) begin bad++; $display("FAIL full_gnt2: got %b want 1000", gnt_o); end
        sb.push_back(4'b1000);
        step();
        req_i = '0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            sb_check_rvalid($sformatf("full_drain[%0d]", i));
            step();
        end
        idle_inputs();
        @(negedge clk);
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL full_busy_end: got %b want 0", busy_o); end
        step();
    endtask

    task automatic test_push_pop();
        // Pointer is at 0 after the last grant to requester 3.
        req_i = 4'b0001; mem_gnt_i = 1'b1; mem_rvalid_i = 1'b0;
        @(negedge clk);
        total++; if (gnt_o !== 4'b0001) begin bad++; $display("FAIL pp_gnt0: got %b want 0001", gnt_o); end
        sb.push_back(4'b0001);
        step();
        req_i = 4'b0100; mem_rvalid_i = 1'b1;
        @(negedge clk);
        sb_check_rvalid("pp_rsp0");
        total++; if (gnt_o !== 4'b0100) begin bad++; $display("FAIL pp_gnt1: got %b want 0100", gnt_o); end
        sb.push_back(4'b0100);
        step();
        req_i = 4'b0010; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
        @(negedge clk);
        total++; if (busy_o !== 1'b1) begin bad++; $display("FAIL pp_busy_one: got %b want 1", busy_o); end
        total++; if (mem_req_o !== 1'b1) begin bad++; $display("FAIL pp_not_full: got %b want 1", mem_req_o); end
        step();
        req_i = '0; mem_rvalid_i = 1'b1;
        @(negedge clk);
        sb_check_rvalid("pp_rsp1");
        step();
        idle_inputs();
        @(negedge clk);
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL pp_busy_end: got %b want 0", busy_o); end
        step();
    endtask

    task automatic test_error();
        mem_rvalid_i = 1'b1;
        @(negedge clk);
        total++; if (err_o !== 1'b0) begin bad++; $display("FAIL err_before: got %b want 0", err_o); end
        total++; if (rvalid_o !== 4'b0000) begin bad++; $display("FAIL err_rvalid_empty: got %b want 0000", rvalid_o); end
        step();
        mem_rvalid_i = 1'b0;
        @(negedge clk);
        total++; if (err_o !== 1'b1) begin bad++; $display("FAIL err_set: got %b want 1", err_o); end
        step();
        // Pointer is at 3; requester 1 wins. Its response is lost to the reset below.
        req_i = 4'b0010; mem_gnt_i = 1'b1;
        @(negedge clk);
        total++; if (gnt_o !== 4'b0010) begin bad++; $display("FAIL err_inflight_gnt: got %b want 0010", gnt_o); end
        step();
        idle_inputs();
        rst_n = 1'b0;
        @(negedge clk);
        total++; if (err_o !== 1'b1) begin bad++; $display("FAIL err_sticky: got %b want 1", err_o); end
        step();
        rst_n = 1'b1;
        mem_rvalid_i = 1'b1;
        @(negedge clk);
        total++; if (err_o !== 1'b0) begin bad++; $display("FAIL err_cleared: got %b want 0", err_o); end
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL err_reset_busy: got %b want 0", busy_o); end
        total++; if (rvalid_o !== 4'b0000) begin bad++; $display("FAIL err_late_rvalid: got %b want 0000", rvalid_o); end
        step();
        mem_rvalid_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++; if (err_o !== 1'b1) begin bad++; $display("FAIL err_after_reset[%0d]: got %b want 1", i, err_o); end
            step();
        end
    endtask

`ifdef INSTR_ARB_PERF_EN
    task automatic test_perf();
        rst_n = 1'b0;
        idle_inputs();
        step();
        rst_n = 1'b1;
        req_i = 4'b0001;
        repeat (70000) step();
        @(negedge clk);
        total++; if (stall_cnt_o !== 16'hFFFF) begin bad++; $display("FAIL perf_stall_sat: got %h want ffff", stall_cnt_o); end
        step();
        rst_n = 1'b0;
        req_i = '0;
        step();
        rst_n = 1'b1;
        @(negedge clk);
        total++; if (stall_cnt_o !== 16'h0000) begin bad++; $display("FAIL perf_stall_reset: got %h want 0000", stall_cnt_o); end
        step();
        for (int i = 0; i < 4; i++) begin
            req_i        = (i < 3) ? 4'b1000 : 4'b0000;
            mem_gnt_i    = (i < 3);
            mem_rvalid_i = (i >= 1);
            @(negedge clk);
            if (i >= 1) sb_check_rvalid($sformatf("perf_rsp[%0d]", i));
            if (i < 3) sb.push_back(4'b1000);
            step();
        end
        idle_inputs();
        @(negedge clk);
        total++; if (grant_cnt_o[3*16 +: 16] !== 16'd3) begin bad++; $display("FAIL perf_gnt3: got %0d want 3", grant_cnt_o[3*16 +: 16]); end
        total++; if (grant_cnt_o[0 +: 48] !== 48'd0) begin bad++; $display("FAIL perf_gnt_others: got %h want 0", grant_cnt_o[0 +: 48]); end
        total++; if (stall_cnt_o !== 16'h0000) begin bad++; $display("FAIL perf_no_stall: got %h want 0000", stall_cnt_o); end
        step();
    endtask
`endif

    initial begin
        test_reset();
        test_round_robin();
        test_lock();
        test_full();
        test_push_pop();
        test_error();
`ifdef INSTR_ARB_PERF_EN
        test_perf();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/riscv_instr_port_arbiter.md
# riscv_instr_port_arbiter

Shares one instruction-memory port among NB_REQ L0 prefetch buffers, e.g. cores of a cluster fetching from a common instruction memory. Round-robin arbitration selects one requester per memory grant. Granted requester IDs are queued in order so each response returns to the requester that issued it. Up to MAX_OUTSTANDING granted, unanswered fetches may be in flight.

## Interface
Parameters:
- NB_REQ, 4, number of requesters (2..8)
- ADDR_WIDTH, 32, fetch address width
- DATA_WIDTH, 128, fetch line width
- MAX_OUTSTANDING, 2, depth of the ID queue (1..4)

Ports (one clock; reset is synchronous and active-low):
- clk  in  1  clock; all state changes on the rising edge
- rst_n  in  1  synchronous active-low reset
- req_i  in  NB_REQ  per-requester fetch request
- addr_i  in  NB_REQ*ADDR_WIDTH  flattened addresses; requester k occupies bits [k*ADDR_WIDTH +: ADDR_WIDTH]
- gnt_o  out  NB_REQ  one-hot grant
- rvalid_o  out  NB_REQ  one-hot response valid
- rdata_o  out  DATA_WIDTH  response data, broadcast to all requesters
- mem_req_o  out  1  memory request
- mem_addr_o  out  ADDR_WIDTH  memory address
- mem_gnt_i  in  1  memory grant
- mem_rvalid_i  in  1  memory response valid
- mem_rdata_i  in  DATA_WIDTH  memory response data
- busy_o  out  1  at least one fetch is outstanding
- err_o  out  1  sticky flag: response arrived with no fetch outstanding

## Operation
- The winner is the first active req_i, searched upward from round-robin pointer rr_q, wrapping modulo NB_REQ.
- Lock: when mem_req_o=1 and mem_gnt_i=0, the winner is latched in lock_q, and later-arriving requesters cannot pre-empt it.
  - While locked, mem_addr_o follows addr_i of the locked requester live. This lets a branch redirect the address while still waiting for grant.
  - If the locked requester drops req_i, the lock is released and arbitration restarts in the same cycle.
- mem_req_o is 1 when any req_i=1 and the ID queue is not full. When the queue is full, mem_req_o=0 and all gnt_o=0, even if mem_rvalid_i pops an entry in the same cycle. There is no combinational path from mem_rvalid_i to mem_req_o.
- Handshake occurs when mem_req_o and mem_gnt_i are both 1:
  - gnt_o[winner]=1 in that cycle (combinational from mem_gnt_i)
  - the winner's one-hot ID is pushed into the queue
  - rr_q becomes (winner+1) mod NB_REQ
  - lock_q is cleared
- Response routing:
  - rvalid_o = queue head ID, gated by mem_rvalid_i.
  - rdata_o = mem_rdata_i, unregistered.
  - mem_rvalid_i pops the queue.
- A push and a pop in the same cycle are both performed; the queue occupancy is unchanged.
- If mem_rvalid_i=1 while the queue is empty:
  - all rvalid_o=0
  - err_o is set to 1 and stays 1 until reset.
- busy_o = queue not empty.

## Timing
- Request path is combinational: req_i/addr_i to mem_req_o/mem_addr_o, and mem_gnt_i to gnt_o, all in the same cycle.
- Response path is combinational: mem_rvalid_i/mem_rdata_i to rvalid_o/rdata_o, zero latency.
- The arbiter adds no bubble: a requester may be granted on every cycle its request and the memory grant coincide, subject to the queue not being full.
- While rst_n=0: mem_req_o=0, gnt_o=0, rvalid_o=0.
- After reset: rr_q=0, lock_q empty, queue empty, err_o=0, busy_o=0, counters 0.
- Reset mid-operation discards the outstanding IDs. A response that arrives after reset is therefore unmatched and sets err_o.

## Configuration
- INSTR_ARB_PERF_EN defined:
  - adds output port grant_cnt_o, NB_REQ*16 bits: per-requester grant counters, incremented on each handshake
  - adds output port stall_cnt_o, 16 bits: counts cycles with any req_i=1 and no handshake
  - all counters saturate at 16'hFFFF and are cleared by reset
- INSTR_ARB_PERF_EN undefined: neither port exists, and no counter logic is built.

## Structure
- Package riscv_instr_arb_pkg holds:
  - default parameter constants
  - the counter width constant (16)
  - function rr_pick(req, ptr), which returns the one-hot winner
- Sub-module riscv_instr_arb_id_fifo: synchronous FIFO of NB_REQ-bit entries, MAX_OUTSTANDING deep.
  - outputs: full, empty, head
  - supports simultaneous push and pop
- Arbitration, lock and routing logic live in the top module.

## Test plan
- Reset, then req_i=4'b0101 held with mem_gnt_i=1 every cycle:
  - expected grant order is 0, 2, 0, 2
  - rvalid_o follows the same order one response per cycle
- req_i[1]=1 with mem_gnt_i=0 for 3 cycles; req_i[0] rises in cycle 2; requester 1 changes its address in cycle 3:
  - requester 1 stays the winner
  - mem_addr_o shows the new address in cycle 3
  - gnt_o=4'b0010 in the cycle mem_gnt_i=1
- MAX_OUTSTANDING=2, two grants issued with no response:
  - mem_req_o=0 while full
  - the first mem_rvalid_i returns rvalid_o to the first requester
  - mem_req_o returns to 1 in the following cycle
- Push and pop in the same cycle with the queue holding one entry:
  - occupancy stays 1
  - routing order is preserved
- mem_rvalid_i=1 when the queue is empty, including right after a mid-flight reset:
  - rvalid_o=0
  - err_o=1 and stays high until reset
- With INSTR_ARB_PERF_EN, 70000 stall cycles:
  - stall_cnt_o=16'hFFFF
  - three grants to requester 3 give grant_cnt_o[3]=3
